// File: rtl/octree_sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// octree_sram_port_ctrl
//
// Request-side controller for the 1024x32 dual-port SRAM macro in the octree
// node store.
//   - After reset, zero-fills words 0..DEPTH-1 through macro port B, one word
//     per cycle.
//   - Then serves one valid/ready request stream (masked write or read) on
//     macro port A.
//   - Read data returns through a small response FIFO. Requests are accepted
//     only while a FIFO slot is guaranteed, so consumer backpressure can never
//     drop a word.
//
// Ports
//   clk, rst                       single clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_we/req_addr/req_wdata/req_wmask
//                                  request payload (wmask bit 1 = write bit)
//   rsp_valid/rsp_ready/rsp_rdata  read response stream, in request order
//   init_done                      high from the first cycle after zero-fill
//   sram_mea/wea/adra/da/wema      macro port A controls, sram_qa port A data
//   sram_meb/web/adrb/db/wemb      macro port B controls (zero-fill only)
//   sram_test1/rme/ls/rm           macro test and margin pins, tied off
// -----------------------------------------------------------------------------
module octree_sram_port_ctrl #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 1024,
  parameter int RSP_DEPTH     = 3,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  // request stream
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  // macro port A
  output logic              sram_mea,
  output logic              sram_wea,
  output logic [ADDR_W-1:0] sram_adra,
  output logic [DATA_W-1:0] sram_da,
  output logic [DATA_W-1:0] sram_wema,
  input  logic [DATA_W-1:0] sram_qa,
  // macro port B
  output logic              sram_meb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_adrb,
  output logic [DATA_W-1:0] sram_db,
  output logic [DATA_W-1:0] sram_wemb,
  // macro test pins
  output logic              sram_test1,
  output logic              sram_rme,
  output logic              sram_ls,
  output logic [3:0]        sram_rm
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(RSP_DEPTH - 1);
  localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(RSP_DEPTH);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   fill_cnt;
  logic                rd_pending;   // a read was issued last cycle; sram_qa is valid now
  logic [DATA_W-1:0]   fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [ADDR_W-1:0]   adra_q;
  logic [DATA_W-1:0]   da_q;
  logic [DATA_W-1:0]   wema_q;

  logic                accept;
  logic                push;
  logic                pop;
  logic [CNT_W:0]      credits_used;

  // A slot is reserved for every read in flight, so the credit check uses
  // only registered state and never looks at rsp_ready.
  assign credits_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending};
  assign req_ready    = ~rst && (state == S_RUN) && (credits_used < CREDIT_MAX);
  assign accept       = req_valid && req_ready;

  assign rsp_valid    = ~rst && (fifo_count != '0);
  assign rsp_rdata    = fifo_mem[rd_ptr];
  assign push         = rd_pending;
  assign pop          = rsp_valid && rsp_ready;

  // Port A follows the request in the same cycle; when idle, address and
  // data hold their last accepted values to avoid toggling the macro pins.
  assign sram_mea     = accept;
  assign sram_wea     = accept && req_we;
  assign sram_adra    = accept ? req_addr  : adra_q;
  assign sram_da      = accept ? req_wdata : da_q;
  assign sram_wema    = accept ? req_wmask : wema_q;

  // Port B is only used for the zero-fill.
  assign sram_meb     = ~rst && (state == S_INIT);
  assign sram_web     = sram_meb;
  assign sram_adrb    = fill_cnt;
  assign sram_db      = '0;
  assign sram_wemb    = '1;

  assign sram_test1   = 1'b0;
  assign sram_rme     = 1'b0;
  assign sram_ls      = 1'b0;
  assign sram_rm      = 4'b0000;

  // NOTE: sequential state uses non-blocking assignments only, and the
  // synchronous reset lives inside the clocked block as its first branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= INIT_ON_RESET ? S_INIT : S_RUN;
      fill_cnt   <= '0;
      init_done  <= 1'b0;
      rd_pending <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      adra_q     <= '0;
      da_q       <= '0;
      wema_q     <= '0;
    end else begin
      if (state == S_INIT) begin
        fill_cnt <= fill_cnt + ADDR_W'(1);
        if (fill_cnt == LAST_ADDR) begin
          state     <= S_RUN;
          init_done <= 1'b1;
        end
      end else begin
        init_done <= 1'b1;
      end

      rd_pending <= accept && !req_we;

      if (accept) begin
        adra_q <= req_addr;
        da_q   <= req_wdata;
        wema_q <= req_wmask;
      end

      if (push) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end

      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count
  // define which entries are live, so stale contents are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sram_qa;
    end
  end

endmodule
